// File: rtl/ps2_pkg.sv
// ps2_pkg: scan codes, key map, FSM states and event type shared by the PS/2 key decoder.
// Defining PS2_EXT_KEYS_EN adds the Up/Down arrow keys (E0-prefixed) as keys 5 and 6.
package ps2_pkg;
  localparam logic [7:0] SC_BRK = 8'hF0;
  localparam logic [7:0] SC_EXT = 8'hE0;
  localparam logic [7:0] SC_W = 8'h1D;
  localparam logic [7:0] SC_S = 8'h1B;
  localparam logic [7:0] SC_C = 8'h21;
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_R = 8'h2D;
  localparam logic [7:0] SC_UP = 8'h75;
  localparam logic [7:0] SC_DOWN = 8'h72;
  localparam logic [2:0] K_W = 3'd0;
  localparam logic [2:0] K_S = 3'd1;
  localparam logic [2:0] K_C = 3'd2;
  localparam logic [2:0] K_SPACE = 3'd3;
  localparam logic [2:0] K_R = 3'd4;
  localparam logic [2:0] K_UP = 3'd5;
  localparam logic [2:0] K_DOWN = 3'd6;
`ifdef PS2_EXT_KEYS_EN
  localparam int NKEYS = 7;
`else
  localparam int NKEYS = 5;
`endif
  typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} state_t;
  typedef struct packed {
    logic [2:0] key;
    logic press;
  } evt_t;
  typedef struct packed {
    logic hit;
    logic [2:0] key;
  } lookup_t;
  // ext selects the E0-prefixed code table; plain codes never match in it
  function automatic lookup_t key_lookup(input logic [7:0] c, input logic ext);
    lookup_t r;
    r = '0;
    if (!ext)
      r = c == SC_W ? {1'b1, K_W} :
          c == SC_S ? {1'b1, K_S} :
          c == SC_C ? {1'b1, K_C} :
          c == SC_SPACE ? {1'b1, K_SPACE} :
          c == SC_R ? {1'b1, K_R} : 4'd0;
`ifdef PS2_EXT_KEYS_EN
    else
      r = c == SC_UP ? {1'b1, K_UP} : c == SC_DOWN ? {1'b1, K_DOWN} : 4'd0;
`endif
    return r;
  endfunction
endpackage

// File: rtl/ps2_evt_fifo.sv
// ps2_evt_fifo: synchronous event FIFO; accepts a push on full when a pop happens in the same cycle.
// Drops a push on full otherwise and latches a sticky overflow flag.
module ps2_evt_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         overflow
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic full, do_pop, do_push;
  assign empty = wr_ptr == rd_ptr;
  assign full = (wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}};
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout = mem[rd_ptr[AW-1:0]];
  always_ff @(posedge clk)
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= din;
      wr_ptr <= wr_ptr + (AW+1)'(do_push);
      rd_ptr <= rd_ptr + (AW+1)'(do_pop);
      overflow <= overflow || (push && !do_push);
    end
endmodule

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: turns PS/2 scan-code bytes into held key levels and a press/release event queue.
// Extended arrow keys are decoded only when PS2_EXT_KEYS_EN is defined.
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TIMEOUT = 1000000
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             code_valid,
  input  logic [7:0]       code,
  output logic [NKEYS-1:0] key_state,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [2:0]       evt_key,
  output logic             evt_press,
  output logic             err,
  output logic             overflow
);
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT - 1);
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic timeout, err_n, act, act_press, fifo_empty;
  lookup_t hit;
  evt_t head;
  assign timeout = state != IDLE && !code_valid && cnt == TMAX;
  assign hit = key_lookup(code, state == EXT || state == EXT_BRK);
  always_ff @(posedge clk)
    if (!resetn) begin
      state <= IDLE;
      cnt <= '0;
      err <= 1'b0;
      key_state <= '0;
    end else begin
      state <= state_n;
      err <= err_n;
      cnt <= code_valid || state == IDLE ? '0 : cnt == TMAX ? cnt : cnt + CW'(1);
      if (act) key_state[hit.key] <= act_press;
    end
  always_comb begin
    state_n = state;
    if (timeout)
      state_n = IDLE;
    else if (code_valid)
      case (state)
        IDLE: state_n = code == SC_BRK ? BRK : code == SC_EXT ? EXT : IDLE;
        BRK: state_n = code == SC_BRK ? BRK : IDLE;
        EXT: state_n = code == SC_BRK ? EXT_BRK : IDLE;
        default: state_n = IDLE;
      endcase
  end
  // a press only acts on a released key and a release only on a held one, which kills typematic repeats
  always_comb begin
    err_n = timeout || (code_valid && state != IDLE && code == SC_EXT);
    act_press = state == IDLE || state == EXT;
    act = code_valid && hit.hit && key_state[hit.key] != act_press;
  end
  ps2_evt_fifo #(.DEPTH(DEPTH), .W(4)) u_fifo (
    .clk(clk),
    .resetn(resetn),
    .push(act),
    .pop(evt_ready),
    .din({hit.key, act_press}),
    .dout(head),
    .empty(fifo_empty),
    .overflow(overflow)
  );
  assign evt_valid = !fifo_empty;
  assign evt_key = head.key;
  assign evt_press = head.press;
endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb_ps2_key_decoder: directed self-checking bench for ps2_key_decoder (DEPTH=4, TIMEOUT=16).
module tb_ps2_key_decoder;
  import ps2_pkg::*;
  localparam int TO = 16;
  logic clk = 1'b0;
  logic resetn, code_valid, evt_ready, evt_valid, evt_press, err, overflow;
  logic [7:0] code;
  logic [NKEYS-1:0] key_state;
  logic [2:0] evt_key;
  int passed = 0;
  int failed = 0;
  int total = 0;
  logic errs;

  ps2_key_decoder #(.DEPTH(4), .TIMEOUT(TO)) dut (
    .clk(clk),
    .resetn(resetn),
    .code_valid(code_valid),
    .code(code),
    .key_state(key_state),
    .evt_valid(evt_valid),
    .evt_ready(evt_ready),
    .evt_key(evt_key),
    .evt_press(evt_press),
    .err(err),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] c);
    code = c;
    code_valid = 1'b1;
    tick();
    code_valid = 1'b0;
    code = 8'h00;
  endtask

  task automatic pop_check(input string tag, input logic [2:0] k, input logic p);
    check({tag, ".valid"}, 32'(evt_valid), 32'd1);
    check({tag, ".key"}, 32'(evt_key), 32'(k));
    check({tag, ".press"}, 32'(evt_press), 32'(p));
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
  endtask

  initial begin
    resetn = 1'b0;
    code_valid = 1'b0;
    code = 8'h00;
    evt_ready = 1'b0;
    tick();
    tick();
    check("rst.key_state", 32'(key_state), 32'd0);
    check("rst.evt_valid", 32'(evt_valid), 32'd0);
    check("rst.evt_key", 32'(evt_key), 32'd0);
    check("rst.evt_press", 32'(evt_press), 32'd0);
    check("rst.err", 32'(err), 32'd0);
    check("rst.overflow", 32'(overflow), 32'd0);
    resetn = 1'b1;
    tick();
    send(8'h1D);
    check("w_press.key_state", 32'(key_state), 32'h01);
    pop_check("w_press", 3'd0, 1'b1);
    check("w_press.empty", 32'(evt_valid), 32'd0);
    send(8'hF0);
    check("brk.err", 32'(err), 32'd0);
    send(8'h1D);
    check("w_rel.key_state", 32'(key_state), 32'h00);
    pop_check("w_rel", 3'd0, 1'b0);
    send(8'h29);
    send(8'h29);
    send(8'h29);
    check("typematic.key_state", 32'(key_state), 32'h08);
    pop_check("typematic", 3'd3, 1'b1);
    check("typematic.single", 32'(evt_valid), 32'd0);
    send(8'hF0);
    send(8'h29);
    pop_check("space_rel", 3'd3, 1'b0);
    send(8'h1D);
    send(8'h1B);
    send(8'h21);
    send(8'h29);
    check("fill.overflow_before", 32'(overflow), 32'd0);
    send(8'h2D);
    check("fill.overflow", 32'(overflow), 32'd1);
    check("fill.key_state", 32'(key_state), 32'h1F);
    pop_check("drain0", 3'd0, 1'b1);
    pop_check("drain1", 3'd1, 1'b1);
    pop_check("drain2", 3'd2, 1'b1);
    pop_check("drain3", 3'd3, 1'b1);
    check("drain.empty", 32'(evt_valid), 32'd0);
    do_reset();
    check("rst2.overflow", 32'(overflow), 32'd0);
    check("rst2.key_state", 32'(key_state), 32'd0);
    send(8'hF0);
    errs = 1'b0;
    for (int i = 1; i < TO; i++) begin
      tick();
      errs = errs | err;
    end
    check("timeout.early", 32'(errs), 32'd0);
    tick();
    check("timeout.err", 32'(err), 32'd1);
    tick();
    check("timeout.err_pulse", 32'(err), 32'd0);
    send(8'h1B);
    check("after_to.key_state", 32'(key_state), 32'h02);
    pop_check("after_to", 3'd1, 1'b1);
    send(8'hF0);
    send(8'hE0);
    check("brk_e0.err", 32'(err), 32'd1);
    send(8'hF0);
    check("brk_e0.err_clear", 32'(err), 32'd0);
    send(8'h1B);
    check("brk_e0.key_state", 32'(key_state), 32'h00);
    pop_check("brk_e0_rel", 3'd1, 1'b0);
    send(8'hE0);
    send(8'h75);
`ifdef PS2_EXT_KEYS_EN
    check("up_press.key_state", 32'(key_state), 32'h20);
    pop_check("up_press", 3'd5, 1'b1);
`else
    check("up_press.key_state", 32'(key_state), 32'h00);
    check("up_press.none", 32'(evt_valid), 32'd0);
`endif
    send(8'hE0);
    send(8'hF0);
    send(8'h75);
    check("up_rel.key_state", 32'(key_state), 32'h00);
`ifdef PS2_EXT_KEYS_EN
    pop_check("up_rel", 3'd5, 1'b0);
`else
    check("up_rel.none", 32'(evt_valid), 32'd0);
`endif
    send(8'hE0);
    send(8'hE0);
    check("ext_e0.err", 32'(err), 32'd1);
    send(8'h1D);
    check("ext_e0.key_state", 32'(key_state), 32'h01);
    pop_check("ext_e0_w", 3'd0, 1'b1);
    send(8'hF0);
    do_reset();
    check("abort.key_state", 32'(key_state), 32'h00);
    check("abort.empty", 32'(evt_valid), 32'd0);
    send(8'h1D);
    check("abort_w.key_state", 32'(key_state), 32'h01);
    send(8'h1B);
    send(8'h21);
    send(8'h29);
    send(8'hF0);
    evt_ready = 1'b1;
    send(8'h1D);
    evt_ready = 1'b0;
    check("full_pop.overflow", 32'(overflow), 32'd0);
    pop_check("full_pop1", 3'd1, 1'b1);
    pop_check("full_pop2", 3'd2, 1'b1);
    pop_check("full_pop3", 3'd3, 1'b1);
    pop_check("full_pop4", 3'd0, 1'b0);
    check("full_pop.empty", 32'(evt_valid), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
